ctrl_decode_stage: RTL and testbench
====================================

Name: ctrl_decode_stage

Overview:
- Registered successor to the combinational control unit: decodes a 32-bit RV32I/RV64I instruction into control bundles, held in an ID/EX-style output register with valid/ready handshakes.
- Adds full branch/load/store coverage, AUIPC, an RV64 word-op mode, an illegal-instruction flag, pipeline flush, and a multi-cycle sequencer for M-extension ops.
- Sits between the IF/ID register and the execute stage.

Parameters:
- RV64, 1: 1 accepts opcodes 0x1B/0x3B (word ops); 0 marks them illegal.
- MUL_LAT, 2: cycles from accept to out_valid for MUL-class ops (≥1).
- DIV_LAT, 8: cycles from accept to out_valid for DIV/REM ops (≥1).
- CNT_W, 4: width of the MDU countdown counter; must hold max(MUL_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  instruction word
- flush  in  1  discard held or in-flight instruction
- out_valid  out  1  control bundle valid
- out_ready  in  1  downstream consumes the bundle
- reg_write, mem_to_reg, mem_read, mem_write, alu_src, jal, jalr, is_branch, auipc, word_op, load_unsigned, illegal  out  1 each  registered control flags
- branch_type  out  3  funct3 of branch
- imm_src  out  3  I=0, S=1, SB=2, U=3, UJ=4
- alu_op  out  4  R=0, I=1, S=2, JAL=3, LOAD=4, BR=5, LUI=7, AUIPC=8, MDU=9
- mem_size  out  2  00 byte, 01 half, 10 word, 11 double
- mdu_op  out  3  funct3 of the M op
- busy  out  1  MDU countdown active

Behaviour:
- Reset: all outputs 0 (imm_src = I, alu_op = R), state IDLE, counter 0, in_ready 0 during rst.
- in_ready = !rst && !flush && state==IDLE && (!out_valid || out_ready). Transfer = in_valid && in_ready.
- Decode on transfer, registered the next edge. Opcodes follow the RISC-V spec:
  - 0x33 R; 0x13 I; 0x03 load; 0x23 store; 0x63 branch; 0x6F JAL; 0x67 JALR (funct3 must be 0); 0x37 LUI; 0x17 AUIPC; 0x1B/0x3B word forms with word_op=1.
- Load: mem_size = funct3[1:0]; load_unsigned = funct3[2]. Illegal funct3 values:
  - load: 011 when RV64=0, and 111
  - store: funct3[2]=1, or 011 when RV64=0
- Branch: branch_type = funct3; funct3 010 and 011 are illegal.
- Illegal instruction: illegal=1, out_valid=1 after normal latency, all enable flags 0 (reg_write, mem_read, mem_write, jal, jalr, is_branch).
- Non-MDU latency: 1 cycle (out_valid high the cycle after transfer).
- MDU op: opcode 0x33/0x3B with funct7 = 0x01.
  - On transfer: state→MDU, busy=1, counter = LAT-1, where LAT = DIV_LAT if funct3[2] else MUL_LAT. out_valid stays 0.
  - Each cycle the counter decrements. When it equals 0: out_valid=1, state→IDLE, busy=0.
  - Net effect: out_valid asserts exactly LAT cycles after transfer.
  - If LAT=1, the MDU state is skipped and latency is 1.
- Output hold: while out_valid && !out_ready, all outputs stay stable. On out_valid && out_ready with no new transfer, out_valid→0; other fields may hold stale values.
- Back-to-back: consume and transfer in the same cycle gives an uninterrupted stream with no bubble.
- flush (priority below rst, above everything else):
  - next edge: out_valid=0, busy=0, state IDLE, counter 0
  - any instr presented that cycle is not accepted
  - flush during an MDU countdown aborts it; no out_valid is produced
- rst during a countdown: same as flush, plus all outputs cleared.
- Unknown opcode: illegal path.

Optional Feature:
- Macro CTRL_DECODE_MDU_EN.
- Defined: MDU decode and countdown as above; alu_op=MDU, reg_write=1, mdu_op=funct3.
- Undefined: funct7=0x01 on 0x33/0x3B decodes illegal; no MDU state or counter logic is built; busy is tied to 0; MUL_LAT, DIV_LAT and CNT_W are unused.

Test Plan:
- rst held 3 cycles → every output 0, in_ready 0; release → in_ready 1.
- instr 0x00A30293 (addi), out_ready=1 → next cycle out_valid=1, reg_write=1, alu_src=1, alu_op=1, imm_src=0.
- lhu 0x0052D283 with out_ready=0 for 4 cycles → bundle stable (mem_read=1, mem_size=01, load_unsigned=1), in_ready 0; out_ready=1 → consumed, in_ready 1.
- With CTRL_DECODE_MDU_EN defined, div 0x0262C2B3, DIV_LAT=8 → busy=1 for 7 cycles, out_valid on cycle 8, mdu_op=100; repeat without the macro → illegal=1 at latency 1.
- MDU countdown with flush at cycle 3 → out_valid never asserts, busy=0 next cycle; a following addi accepted the cycle after.
- Branch 0x0000A063 (funct3 010) → illegal=1, is_branch=0; beq 0x00000063 → is_branch=1, branch_type=000, imm_src=2.

Source files
------------

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered RV32I/RV64I control decoder sitting between
// IF/ID and execute. Decoded bundle is held in an output register with a
// valid/ready handshake; flush discards held or in-flight work.
// Optional macro CTRL_DECODE_MDU_EN builds M-extension decode plus a
// multi-cycle countdown sequencer; without it funct7=0x01 R-ops are illegal.
module ctrl_decode_stage #(
  parameter int RV64    = 1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        jal,
  output logic        jalr,
  output logic        is_branch,
  output logic        auipc,
  output logic        word_op,
  output logic        load_unsigned,
  output logic        illegal,
  output logic [2:0]  branch_type,
  output logic [2:0]  imm_src,
  output logic [3:0]  alu_op,
  output logic [1:0]  mem_size,
  output logic [2:0]  mdu_op,
  output logic        busy
);

  localparam logic [3:0] ALU_R     = 4'd0;
  localparam logic [3:0] ALU_I     = 4'd1;
  localparam logic [3:0] ALU_S     = 4'd2;
  localparam logic [3:0] ALU_JAL   = 4'd3;
  localparam logic [3:0] ALU_LOAD  = 4'd4;
  localparam logic [3:0] ALU_BR    = 4'd5;
  localparam logic [3:0] ALU_LUI   = 4'd7;
  localparam logic [3:0] ALU_AUIPC = 4'd8;
  localparam logic [3:0] ALU_MDU   = 4'd9;

  localparam logic [2:0] IMM_I  = 3'd0;
  localparam logic [2:0] IMM_S  = 3'd1;
  localparam logic [2:0] IMM_SB = 3'd2;
  localparam logic [2:0] IMM_U  = 3'd3;
  localparam logic [2:0] IMM_UJ = 3'd4;

  localparam bit RV64_OK = (RV64 != 0);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       jal;
    logic       jalr;
    logic       is_branch;
    logic       auipc;
    logic       word_op;
    logic       load_unsigned;
    logic       illegal;
    logic [2:0] branch_type;
    logic [2:0] imm_src;
    logic [3:0] alu_op;
    logic [1:0] mem_size;
    logic [2:0] mdu_op;
  } ctl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  ctl_t       ctl_p0;
  logic       bad_p0;
  logic       dec_mdu;
  ctl_t       ctl_p1;
  logic       vld_p1;
  logic       idle;
  logic       mdu_long;
  logic       mdu_done;
  logic       xfer;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields are consumed by the register file, not here.
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  // Stage p0: combinational decode of the presented instruction.
  always_comb begin
    ctl_p0  = '0;
    bad_p0  = 1'b0;
    dec_mdu = 1'b0;
    case (opcode)
      7'h33, 7'h3B: begin
        if (opcode == 7'h3B && !RV64_OK) begin
          bad_p0 = 1'b1;
        end else if (funct7 == 7'h01) begin
`ifdef CTRL_DECODE_MDU_EN
          ctl_p0.reg_write = 1'b1;
          ctl_p0.alu_op    = ALU_MDU;
          ctl_p0.mdu_op    = funct3;
          ctl_p0.word_op   = (opcode == 7'h3B);
          dec_mdu          = 1'b1;
`else
          bad_p0 = 1'b1;
`endif
        end else begin
          ctl_p0.reg_write = 1'b1;
          ctl_p0.alu_op    = ALU_R;
          ctl_p0.word_op   = (opcode == 7'h3B);
        end
      end
      7'h13, 7'h1B: begin
        bad_p0           = (opcode == 7'h1B) && !RV64_OK;
        ctl_p0.reg_write = 1'b1;
        ctl_p0.alu_src   = 1'b1;
        ctl_p0.alu_op    = ALU_I;
        ctl_p0.imm_src   = IMM_I;
        ctl_p0.word_op   = (opcode == 7'h1B);
      end
      7'h03: begin
        bad_p0 = (funct3 == 3'b111) || (funct3 == 3'b011 && !RV64_OK);
        ctl_p0.reg_write     = 1'b1;
        ctl_p0.mem_to_reg    = 1'b1;
        ctl_p0.mem_read      = 1'b1;
        ctl_p0.alu_src       = 1'b1;
        ctl_p0.alu_op        = ALU_LOAD;
        ctl_p0.imm_src       = IMM_I;
        ctl_p0.mem_size      = funct3[1:0];
        ctl_p0.load_unsigned = funct3[2];
      end
      7'h23: begin
        bad_p0 = funct3[2] || (funct3 == 3'b011 && !RV64_OK);
        ctl_p0.mem_write = 1'b1;
        ctl_p0.alu_src   = 1'b1;
        ctl_p0.alu_op    = ALU_S;
        ctl_p0.imm_src   = IMM_S;
        ctl_p0.mem_size  = funct3[1:0];
      end
      7'h63: begin
        bad_p0 = (funct3 == 3'b010) || (funct3 == 3'b011);
        ctl_p0.is_branch   = 1'b1;
        ctl_p0.branch_type = funct3;
        ctl_p0.alu_op      = ALU_BR;
        ctl_p0.imm_src     = IMM_SB;
      end
      7'h6F: begin
        ctl_p0.reg_write = 1'b1;
        ctl_p0.jal       = 1'b1;
        ctl_p0.alu_op    = ALU_JAL;
        ctl_p0.imm_src   = IMM_UJ;
      end
      7'h67: begin
        bad_p0 = (funct3 != 3'b000);
        ctl_p0.reg_write = 1'b1;
        ctl_p0.jalr      = 1'b1;
        ctl_p0.alu_src   = 1'b1;
        ctl_p0.alu_op    = ALU_JAL;
        ctl_p0.imm_src   = IMM_I;
      end
      7'h37: begin
        ctl_p0.reg_write = 1'b1;
        ctl_p0.alu_src   = 1'b1;
        ctl_p0.alu_op    = ALU_LUI;
        ctl_p0.imm_src   = IMM_U;
      end
      7'h17: begin
        ctl_p0.reg_write = 1'b1;
        ctl_p0.alu_src   = 1'b1;
        ctl_p0.auipc     = 1'b1;
        ctl_p0.alu_op    = ALU_AUIPC;
        ctl_p0.imm_src   = IMM_U;
      end
      default: bad_p0 = 1'b1;
    endcase
    // An illegal instruction carries no enables, only the flag.
    if (bad_p0) begin
      ctl_p0         = '0;
      ctl_p0.illegal = 1'b1;
      dec_mdu        = 1'b0;
    end
  end

`ifdef CTRL_DECODE_MDU_EN
  typedef enum logic {IDLE, MDU} state_t;

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lat_cnt;

  // A latency of one needs no countdown and goes straight to the output.
  assign lat_cnt  = funct3[2] ? DIV_CNT : MUL_CNT;
  assign mdu_long = dec_mdu && (lat_cnt != '0);
  assign idle     = (state_q == IDLE);
  assign busy     = (state_q == MDU);
  assign mdu_done = (state_q == MDU) && (cnt_q == CNT_W'(1));

  // Sequencer next-state: enter countdown on a long MDU accept, leave on last tick.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (xfer && mdu_long) state_d = MDU;
        MDU:     if (cnt_q == CNT_W'(1)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequencer state register and countdown counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        cnt_q <= '0;
      end else if (xfer && mdu_long) begin
        cnt_q <= lat_cnt;
      end else if (state_q == MDU) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end
`else
  logic unused_mdu;

  assign idle       = 1'b1;
  assign mdu_long   = 1'b0;
  assign mdu_done   = 1'b0;
  assign busy       = 1'b0;
  assign unused_mdu = dec_mdu ^ (MUL_LAT > DIV_LAT) ^ (CNT_W > 0);
`endif

  assign in_ready = !rst && !flush && idle && (!vld_p1 || out_ready);
  assign xfer     = in_valid && in_ready;

  // Stage p1: ID/EX output register; holds while valid and not consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (xfer) begin
      ctl_p1 <= ctl_p0;
      vld_p1 <= !mdu_long;
    end else if (mdu_done) begin
      vld_p1 <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid     = vld_p1;
  assign reg_write     = ctl_p1.reg_write;
  assign mem_to_reg    = ctl_p1.mem_to_reg;
  assign mem_read      = ctl_p1.mem_read;
  assign mem_write     = ctl_p1.mem_write;
  assign alu_src       = ctl_p1.alu_src;
  assign jal           = ctl_p1.jal;
  assign jalr          = ctl_p1.jalr;
  assign is_branch     = ctl_p1.is_branch;
  assign auipc         = ctl_p1.auipc;
  assign word_op       = ctl_p1.word_op;
  assign load_unsigned = ctl_p1.load_unsigned;
  assign illegal       = ctl_p1.illegal;
  assign branch_type   = ctl_p1.branch_type;
  assign imm_src       = ctl_p1.imm_src;
  assign alu_op        = ctl_p1.alu_op;
  assign mem_size      = ctl_p1.mem_size;
  assign mdu_op        = ctl_p1.mdu_op;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: driver pushes expected bundles on
// accept, monitor compares every cycle against handshake/latency expectations.
module tb_ctrl_decode_stage;

  localparam int RV64    = 1;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  localparam logic [31:0] ADDI  = 32'h00A30293;
  localparam logic [31:0] LHU   = 32'h0052D283;
  localparam logic [31:0] DIV   = 32'h0262C2B3;
  localparam logic [31:0] BR010 = 32'h0000A063;
  localparam logic [31:0] BEQ   = 32'h00000063;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        reg_write, mem_to_reg, mem_read, mem_write, alu_src, jal, jalr;
  logic        is_branch, auipc, word_op, load_unsigned, illegal;
  logic [2:0]  branch_type, imm_src, mdu_op;
  logic [3:0]  alu_op;
  logic [1:0]  mem_size;
  logic        busy;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       jal;
    logic       jalr;
    logic       is_branch;
    logic       auipc;
    logic       word_op;
    logic       load_unsigned;
    logic       illegal;
    logic [2:0] branch_type;
    logic [2:0] imm_src;
    logic [3:0] alu_op;
    logic [1:0] mem_size;
    logic [2:0] mdu_op;
  } bnd_t;

  typedef struct {
    bnd_t b;
    int   lat;
    int   xfer;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic rst_edge = 1'b1;
  bnd_t act;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  assign act = {reg_write, mem_to_reg, mem_read, mem_write, alu_src, jal, jalr,
                is_branch, auipc, word_op, load_unsigned, illegal, branch_type,
                imm_src, alu_op, mem_size, mdu_op};

  ctrl_decode_stage #(.RV64(RV64), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
    .mem_write(mem_write), .alu_src(alu_src), .jal(jal), .jalr(jalr),
    .is_branch(is_branch), .auipc(auipc), .word_op(word_op),
    .load_unsigned(load_unsigned), .illegal(illegal), .branch_type(branch_type),
    .imm_src(imm_src), .alu_op(alu_op), .mem_size(mem_size), .mdu_op(mdu_op),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  // Reference decoder built from the ISA rules: legal funct3 sets as bitmasks.
  function automatic void model(input logic [31:0] ins, output bnd_t b, output int lat);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [7:0] ld_ok;
    logic [7:0] st_ok;
    logic [7:0] br_ok;
    logic       ok;
    op    = ins[6:0];
    f3    = ins[14:12];
    f7    = ins[31:25];
    ld_ok = (RV64 != 0) ? 8'b0111_1111 : 8'b0111_0111;
    st_ok = (RV64 != 0) ? 8'b0000_1111 : 8'b0000_0111;
    br_ok = 8'b1111_0011;
    b     = '0;
    lat   = 1;
    ok    = 1'b1;
    case (op)
      7'h33, 7'h3B: begin
        ok          = (op == 7'h33) || (RV64 != 0);
        b.reg_write = 1'b1;
        b.word_op   = (op == 7'h3B);
        if (f7 == 7'h01) begin
`ifdef CTRL_DECODE_MDU_EN
          b.alu_op = 4'd9;
          b.mdu_op = f3;
          lat      = f3[2] ? DIV_LAT : MUL_LAT;
`else
          ok = 1'b0;
`endif
        end
      end
      7'h13, 7'h1B: begin
        ok = (op == 7'h13) || (RV64 != 0);
        b.reg_write = 1'b1; b.alu_src = 1'b1; b.alu_op = 4'd1;
        b.word_op = (op == 7'h1B);
      end
      7'h03: begin
        ok = ld_ok[f3];
        b.reg_write = 1'b1; b.mem_to_reg = 1'b1; b.mem_read = 1'b1; b.alu_src = 1'b1;
        b.alu_op = 4'd4; b.mem_size = f3[1:0]; b.load_unsigned = f3[2];
      end
      7'h23: begin
        ok = st_ok[f3];
        b.mem_write = 1'b1; b.alu_src = 1'b1; b.alu_op = 4'd2; b.imm_src = 3'd1;
        b.mem_size = f3[1:0];
      end
      7'h63: begin
        ok = br_ok[f3];
        b.is_branch = 1'b1; b.branch_type = f3; b.alu_op = 4'd5; b.imm_src = 3'd2;
      end
      7'h6F: begin
        b.reg_write = 1'b1; b.jal = 1'b1; b.alu_op = 4'd3; b.imm_src = 3'd4;
      end
      7'h67: begin
        ok = (f3 == 3'b000);
        b.reg_write = 1'b1; b.jalr = 1'b1; b.alu_src = 1'b1; b.alu_op = 4'd3;
      end
      7'h37: begin
        b.reg_write = 1'b1; b.alu_src = 1'b1; b.alu_op = 4'd7; b.imm_src = 3'd3;
      end
      7'h17: begin
        b.reg_write = 1'b1; b.alu_src = 1'b1; b.auipc = 1'b1; b.alu_op = 4'd8;
        b.imm_src = 3'd3;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b         = '0;
      b.illegal = 1'b1;
      lat       = 1;
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:  r[6:0] = 7'h33;
      1:  r[6:0] = 7'h3B;
      2:  r[6:0] = 7'h13;
      3:  r[6:0] = 7'h1B;
      4:  r[6:0] = 7'h03;
      5:  r[6:0] = 7'h23;
      6:  r[6:0] = 7'h63;
      7:  r[6:0] = 7'h6F;
      8:  r[6:0] = 7'h67;
      9:  r[6:0] = 7'h37;
      10: r[6:0] = 7'h17;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    if (r[6:0] == 7'h67 && $urandom_range(0, 1) == 1) r[14:12] = 3'b000;
    return r;
  endfunction

  // Drive one cycle of inputs just after the edge; record the expected bundle on accept.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    bnd_t b;
    int   l;
    ent_t e;
    @(posedge clk);
    #1;
    rst = r; in_valid = v; instr = ins; out_ready = ordy; flush = fl;
    #1;
    if (v && in_ready) begin
      model(ins, b, l);
      e.b = b; e.lat = l; e.xfer = cyc;
      q.push_back(e);
    end
  endtask

  // Monitor: mid-cycle comparison of handshake, busy and bundle against the queue head.
  always @(negedge clk) begin
    bit have, ev, eb, er;
    if (rst) begin
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      if (rst_edge) chk("rst_outputs", {35'd0, out_valid, busy, act}, 64'd0);
      q.delete();
    end else begin
      have = (q.size() > 0) && (q[0].xfer < cyc);
      ev   = have && ((cyc - q[0].xfer) >= q[0].lat);
      eb   = have && !ev;
      er   = !flush && (!have || (ev && out_ready));
      chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
      chk("busy", {63'd0, busy}, {63'd0, eb});
      chk("in_ready", {63'd0, in_ready}, {63'd0, er});
      if (ev) chk("bundle", {37'd0, act}, {37'd0, q[0].b});
      if (flush) begin
        while (q.size() > 0 && q[0].xfer < cyc) q.pop_front();
      end else if (ev && out_ready) begin
        q.pop_front();
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // single addi
    step(1'b0, 1'b1, ADDI, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // lhu held under back-pressure, new instr refused meanwhile
    step(1'b0, 1'b1, LHU, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b1, ADDI, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // divide latency
    step(1'b0, 1'b1, DIV, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // flush in the middle of a countdown, then addi accepted right after
    step(1'b0, 1'b1, DIV, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, ADDI, 1'b1, 1'b1);
    step(1'b0, 1'b1, ADDI, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // reset during a countdown
    step(1'b0, 1'b1, DIV, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    repeat (2) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // branches: reserved funct3 then beq
    step(1'b0, 1'b1, BR010, 1'b1, 1'b0);
    step(1'b0, 1'b1, BEQ, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // uninterrupted stream
    repeat (4) step(1'b0, 1'b1, ADDI, 1'b1, 1'b0);
    // randomized traffic with back-pressure and occasional flush
    repeat (3000)
      step(1'b0, ($urandom % 4) != 0, rand_instr(), ($urandom % 4) != 0, ($urandom % 64) == 0);
    repeat (12) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
